arb_wait_memory: RTL

Parametrised successor to the single-port system RAM: one synchronous memory array shared by a CPU port and a DMA/debug port, with fixed configurable wait states, a Ready/Ack handshake, round-robin arbitration and a write-protected ROM window. It sits between the 6502 core bus and the memory array, so loaders and monitors can access memory without a second copy of the array.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 37 +++
 rtl/arb_wait_memory.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for arb_wait_memory and its RAM sub-module.
//   state_e : access sequencer states (idle / wait-state countdown / array access)
//   port_e  : identifies which requester owns the current access
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  // Largest wait-state count the 4-bit counter can hold.
  localparam int unsigned MAX_WAIT_STATES = 15;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_CPU) ? PORT_DMA : PORT_CPU;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous read-first RAM.
//   clk   : clock, all operations on its rising edge
//   en    : perform one access this edge
//   we    : commit wdata at addr (only when en is high)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; on a write it returns the pre-write contents
// The array has no reset; contents survive a system reset.
module mem_array #(
  parameter int    ADDR_W    = 16,
  parameter int    DATA_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Read-first: the old word is captured on the same edge the new one is written.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      if (we) begin
        mem_q[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/arb_wait_memory.sv
// Shared memory with two requesters (CPU, DMA/debug), fixed wait states,
// round-robin arbitration and a write-protected ROM window.
//   CLK, RST_N                  : clock, asynchronous active-low reset
//   Req/WE/Address/DataIn       : CPU request, held until Ready
//   DataOut, Ready              : CPU read data (valid with Ready), one-cycle completion strobe
//   DmaReq/DmaWE/DmaAddress/DmaDataIn : DMA request, held until DmaAck
//   DmaDataOut, DmaAck          : DMA read data (valid with DmaAck), one-cycle completion strobe
//   WpError                     : pulses with the strobe when the write was blocked
module arb_wait_memory
  import mem_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 8,
  parameter int unsigned        WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0]  ROM_BASE    = ADDR_W'(16'hF000),
  parameter int unsigned        ROM_SIZE    = 4096,
  parameter string              INIT_FILE   = ""
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  input  logic              DmaReq,
  input  logic              DmaWE,
  input  logic [ADDR_W-1:0] DmaAddress,
  input  logic [DATA_W-1:0] DmaDataIn,
  output logic [DATA_W-1:0] DmaDataOut,
  output logic              DmaAck,
  output logic              WpError
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  // Window bounds are one bit wider than the address so a window ending at
  // the top of the address space has an upper bound of 2**ADDR_W, not 0.
  localparam logic [ADDR_W:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [ADDR_W:0] ROM_HI = ROM_LO + (ADDR_W+1)'(ROM_SIZE);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  port_e             prio_q, prio_d;
  port_e             gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              dma_ack_q, dma_ack_d;
  logic              wp_err_q, wp_err_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] dma_hold_q, dma_hold_d;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              rom_hit;
  port_e             grant;

  assign rom_hit = (ROM_SIZE != 0) &&
                   ({1'b0, addr_q} >= ROM_LO) &&
                   ({1'b0, addr_q} <  ROM_HI);

  // Single requester always wins; on contention the priority port wins.
  assign grant = (Req && (!DmaReq || (prio_q == PORT_CPU))) ? PORT_CPU : PORT_DMA;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    dma_ack_d  = 1'b0;
    wp_err_d   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    // Each port keeps the data of its last completed access once its strobe ends.
    cpu_hold_d = ready_q   ? mem_rdata : cpu_hold_q;
    dma_hold_d = dma_ack_q ? mem_rdata : dma_hold_q;

    case (state_q)
      IDLE: begin
        if (Req || DmaReq) begin
          gnt_d   = grant;
          prio_d  = other_port(grant);
          we_d    = (grant == PORT_CPU) ? WE      : DmaWE;
          addr_d  = (grant == PORT_CPU) ? Address : DmaAddress;
          wdata_d = (grant == PORT_CPU) ? DataIn  : DmaDataIn;
          cnt_d   = WS_INIT;
          state_d = (WS_INIT == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q && !rom_hit;
        ready_d   = (gnt_q == PORT_CPU);
        dma_ack_d = (gnt_q == PORT_DMA);
        wp_err_d  = we_q && rom_hit;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- control / output registers ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      prio_q     <= PORT_CPU;
      gnt_q      <= PORT_CPU;
      ready_q    <= 1'b0;
      dma_ack_q  <= 1'b0;
      wp_err_q   <= 1'b0;
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      gnt_q      <= gnt_d;
      ready_q    <= ready_d;
      dma_ack_q  <= dma_ack_d;
      wp_err_q   <= wp_err_d;
      cpu_hold_q <= cpu_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

  // ---- latched request fields (only consumed after a grant) ----
  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  mem_array #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem_array (
    .clk   (CLK),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // During the strobe cycle the RAM output register holds the fresh word.
  assign DataOut    = ready_q   ? mem_rdata : cpu_hold_q;
  assign DmaDataOut = dma_ack_q ? mem_rdata : dma_hold_q;
  assign Ready      = ready_q;
  assign DmaAck     = dma_ack_q;
  assign WpError    = wp_err_q;

endmodule
